// File: rtl/dcache.sv
// dcache: direct-mapped, one-word-per-line, write-through/no-allocate data cache
// with an uncached trigger word at 0x100 and a req/ack backing-memory port.
module dcache #(
    parameter int WIDTH = 32,
    parameter int LINES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] WD,
    input  logic [2:0]       modeAddr,
    input  logic             RE,
    input  logic             WE,
    input  logic             trigger,
    output logic [WIDTH-1:0] RD,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [16:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 15 - IW;
    localparam logic [14:0] IO_WORD = 15'h40;
    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
    state_t           state_q, state_d;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q [LINES];
    logic [31:0]      data_q [LINES];
    logic [16:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [IW-1:0]    idx, fidx;
    logic [TW-1:0]    tag, ftag;
    logic             mode_ok, is_ld, is_st, io, hit, fhit, stall_c;
    logic [31:0]      word, ext, rd_c, wpos;
    logic [15:0]      half;
    logic [7:0]       byt;
    logic [3:0]       strb;
    logic             unused_a;
    assign unused_a = ^A[WIDTH-1:17];
    assign idx      = A[IW+1:2];
    assign tag      = A[16:IW+2];
    assign fidx     = addr_q[IW+1:2];
    assign ftag     = addr_q[16:IW+2];
    assign mode_ok  = modeAddr >= 3'd1 && modeAddr <= 3'd5;
    assign is_st    = WE && mode_ok;
    assign is_ld    = RE && !WE && mode_ok;
    // The whole trigger word is uncached so no byte of it can ever alias into a line.
    assign io       = A[16:2] == IO_WORD;
    assign hit      = valid_q[idx] && tag_q[idx] == tag;
    assign fhit     = valid_q[fidx] && tag_q[fidx] == ftag && addr_q[16:2] != IO_WORD;
    assign word     = data_q[idx];
    assign half     = A[1] ? word[31:16] : word[15:0];
    assign byt      = word[{A[1:0], 3'b000} +: 8];
    assign ext      = modeAddr == 3'd1 ? word :
                      modeAddr == 3'd2 ? {{16{half[15]}}, half} :
                      modeAddr == 3'd3 ? {{24{byt[7]}}, byt} :
                      modeAddr == 3'd4 ? {16'b0, half} : {24'b0, byt};
    assign strb     = modeAddr == 3'd1 ? 4'hF :
                      (modeAddr == 3'd2 || modeAddr == 3'd4) ? (A[1] ? 4'b1100 : 4'b0011) :
                      4'b0001 << A[1:0];
    assign wpos     = modeAddr == 3'd1 ? WD[31:0] :
                      (modeAddr == 3'd2 || modeAddr == 3'd4) ? {2{WD[15:0]}} : {4{WD[7:0]}};
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        stall_c = 1'b0;
        rd_c    = '0;
        case (state_q)
            IDLE: begin
                if (is_st) begin
                    stall_c = 1'b1;
                    state_d = WRITE;
                    addr_d  = {A[16:2], 2'b00};
                    wdata_d = wpos;
                    wstrb_d = strb;
                end else if (is_ld) begin
                    if (io) rd_c = {31'b0, trigger};
                    else if (hit) rd_c = ext;
                    else begin
                        stall_c = 1'b1;
                        state_d = FETCH;
                        addr_d  = {A[16:2], 2'b00};
                        wstrb_d = '0;
                    end
                end
            end
            FETCH: begin
                stall_c = 1'b1;
                state_d = mem_ack ? IDLE : FETCH;
            end
            WRITE: begin
                stall_c = !mem_ack;
                state_d = mem_ack ? IDLE : WRITE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            if (state_q == FETCH && mem_ack) valid_q[fidx] <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && state_q == FETCH && mem_ack) begin
            tag_q[fidx]  <= ftag;
            data_q[fidx] <= mem_rdata;
        end
        if (!rst && state_q == WRITE && mem_ack && fhit)
            for (int b = 0; b < 4; b++)
                if (wstrb_q[b]) data_q[fidx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
    assign stall     = !rst && stall_c;
    assign RD        = rst ? '0 : rd_c;
    assign mem_req   = !rst && state_q != IDLE;
    assign mem_we    = !rst && state_q == WRITE;
    assign mem_addr  = rst ? '0 : addr_q;
    assign mem_wdata = rst ? '0 : wdata_q;
    assign mem_wstrb = rst ? '0 : wstrb_q;
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: randomized + directed bench for dcache against a word-level cache
// model with a per-cycle expectation schedule checked on the falling edge.
module tb_dcache;
    localparam int LINES = 64;
    logic        clk = 0, rst, RE, WE, trigger, stall, mem_req, mem_we, mem_ack;
    logic [31:0] A, WD, RD, mem_wdata, mem_rdata;
    logic [2:0]  modeAddr;
    logic [16:0] mem_addr;
    logic [3:0]  mem_wstrb;
    int          nvec = 0, nerr = 0;
    bit          e_chk = 0, e_rdc, e_stall, e_req, e_we;
    bit   [31:0] e_rd, e_wd;
    bit   [16:0] e_addr;
    bit   [3:0]  e_strb;
    bit          mv [LINES];
    bit   [31:0] mtag [LINES];
    bit   [31:0] mdat [LINES];

    dcache #(.WIDTH(32), .LINES(LINES)) dut (
        .clk(clk), .rst(rst), .A(A), .WD(WD), .modeAddr(modeAddr), .RE(RE), .WE(WE),
        .trigger(trigger), .RD(RD), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input bit [31:0] act, input bit [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %h expected %h", n, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (e_chk) begin
        bit [31:0] m;
        m = rst ? 32'hFFFF_FFFF : {{8{e_strb[3]}}, {8{e_strb[2]}}, {8{e_strb[1]}}, {8{e_strb[0]}}};
        if (e_rdc) chk("RD", RD, e_rd);
        chk("stall", 32'(stall), 32'(e_stall));
        chk("mem_req", 32'(mem_req), 32'(e_req));
        if (e_req || rst) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        end
        if (e_we || rst) begin
            chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
            chk("mem_wdata", mem_wdata & m, e_wd & m);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic se(input bit rdc, input bit [31:0] rd, input bit st, input bit req, input bit we,
                      input bit [16:0] ad, input bit [3:0] sb, input bit [31:0] wd);
        e_rdc = rdc; e_rd = rd; e_stall = st; e_req = req; e_we = we;
        e_addr = ad; e_strb = sb; e_wd = wd;
    endtask

    function automatic bit [31:0] ext(input bit [2:0] m, input bit [31:0] a, input bit [31:0] w);
        bit [31:0] b, h;
        b = (w >> (8 * (a % 4))) % 256;
        h = (w >> (16 * ((a / 2) % 2))) % 65536;
        case (m)
            3'd1: return w;
            3'd2: return h >= 32768 ? h - 32'd65536 : h;
            3'd3: return b >= 128 ? b - 32'd256 : b;
            3'd4: return h;
            3'd5: return b;
            default: return 0;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) mv[i] = 0;
    endtask

    // One memory-stage access, held until the cache releases it; the model decides
    // hit/miss/store and schedules the expected outputs cycle by cycle.
    task automatic op(input bit re, input bit we, input bit [2:0] mode, input bit [31:0] a,
                      input bit [31:0] wd, input int lat, input bit [31:0] rdata, input bit trig,
                      input bit pin, input bit [31:0] pin_v, input int pin_stall, input bit [3:0] pin_strb);
        bit [31:0] a17, wa, fr, wdp, msk;
        int idx, n, lane, ns;
        bit ok, st, ld, unc, hit;
        bit [3:0] sb;
        RE = re; WE = we; modeAddr = mode; A = a; WD = wd; trigger = trig;
        mem_ack = 0; mem_rdata = rdata;
        a17 = a % 32'h20000;
        wa = a17 - a17 % 4;
        idx = int'((a17 / 4) % LINES);
        ok = mode >= 1 && mode <= 5;
        st = we && ok;
        ld = re && !we && ok;
        unc = wa == 32'h100;
        hit = mv[idx] && mtag[idx] == a17 / (4 * LINES);
        n = mode == 1 ? 4 : (mode == 2 || mode == 4) ? 2 : 1;
        lane = n == 4 ? 0 : n == 2 ? int'(a17 % 4) / 2 * 2 : int'(a17 % 4);
        sb = 4'(((1 << n) - 1) << lane);
        msk = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
        wdp = (wd & msk) << (8 * lane);
        fr = 0;
        ns = 0;
        if (st) ns = lat + 1;
        else if (ld && !unc && !hit) begin
            ns = lat + 2;
            fr = ext(mode, a17, rdata);
        end else if (ld) fr = unc ? 32'(trig) : ext(mode, a17, mdat[idx]);
        if (pin) begin
            chk("model_stall", 32'(ns), 32'(pin_stall));
            chk("model_value", st ? wdp : fr, pin_v);
            if (st) chk("model_strb", 32'(sb), 32'(pin_strb));
        end
        if (st) begin
            se(0, 0, 1, 0, 0, 0, 0, 0);
            for (int c = 1; c <= lat + 1; c++) begin
                step();
                mem_ack = c == lat + 1;
                se(0, 0, c != lat + 1, 1, 1, 17'(wa), sb, wdp);
            end
            if (!unc && hit)
                for (int b = 0; b < 4; b++)
                    if (sb[b]) mdat[idx] = (mdat[idx] & ~(32'hFF << (8 * b))) | (wdp & (32'hFF << (8 * b)));
        end else if (ld && !unc && !hit) begin
            se(0, 0, 1, 0, 0, 0, 0, 0);
            for (int c = 1; c <= lat + 1; c++) begin
                step();
                mem_ack = c == lat + 1;
                se(0, 0, 1, 1, 0, 17'(wa), 0, 0);
            end
            mv[idx] = 1;
            mtag[idx] = a17 / (4 * LINES);
            mdat[idx] = rdata;
            step();
            mem_ack = 0;
            se(1, fr, 0, 0, 0, 0, 0, 0);
        end else se(1, fr, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        rst = 1; RE = 1; WE = 0; modeAddr = 3'd1; A = 32'h10000; WD = 0; trigger = 1;
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        clear_model();
        step();
        se(1, 0, 0, 0, 0, 0, 0, 0);
        e_chk = 1;
        repeat (3) step();
        rst = 0;
        op(1, 0, 1, 32'h10000, 0, 3, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 5, 0);
        op(1, 0, 1, 32'h10000, 0, 0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0);
        op(1, 0, 3, 32'h10003, 0, 0, 32'h0, 0, 1, 32'hFFFFFFDE, 0, 0);
        op(1, 0, 4, 32'h10002, 0, 0, 32'h0, 0, 1, 32'h0000DEAD, 0, 0);
        op(0, 1, 3, 32'h10001, 32'h55, 2, 32'h0, 0, 1, 32'h00005500, 3, 4'b0010);
        op(1, 0, 1, 32'h10000, 0, 0, 32'h0, 0, 1, 32'hDEAD55EF, 0, 0);
        op(1, 0, 1, 32'h100, 0, 0, 32'h0, 1, 1, 32'h1, 0, 0);
        op(1, 0, 1, 32'h10100, 0, 1, 32'h12345678, 0, 1, 32'h12345678, 3, 0);
        op(1, 0, 1, 32'h10000, 0, 0, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 2, 0);
        op(1, 0, 3'd6, 32'h10000, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0);
        op(0, 0, 3'd1, 32'h10000, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0);
        op(1, 0, 2, 32'h10002, 0, 0, 32'h0, 0, 1, 32'hFFFFCAFE, 0, 0);
        op(1, 0, 2, 32'h10000, 0, 0, 32'h0, 0, 1, 32'hFFFFF00D, 0, 0);
        op(1, 0, 5, 32'h10001, 0, 0, 32'h0, 0, 1, 32'h000000F0, 0, 0);
        op(1, 0, 3, 32'h10000, 0, 0, 32'h0, 0, 1, 32'h0000000D, 0, 0);
        op(0, 1, 2, 32'h10003, 32'h1234ABCD, 1, 32'h0, 0, 1, 32'hABCD0000, 2, 4'b1100);
        op(1, 0, 1, 32'h10000, 0, 0, 32'h0, 0, 1, 32'hABCDF00D, 0, 0);
        op(0, 1, 1, 32'h100, 32'h0BAD0BAD, 0, 32'h0, 1, 1, 32'h0BAD0BAD, 1, 4'b1111);
        op(1, 1, 3, 32'h10002, 32'h77, 0, 32'h0, 0, 1, 32'h00770000, 1, 4'b0100);
        op(1, 0, 1, 32'h10000, 0, 0, 32'h0, 0, 1, 32'hAB77F00D, 0, 0);
        // Reset in the middle of a fill, with the ack landing a cycle late.
        RE = 1; WE = 0; modeAddr = 3'd1; A = 32'h10200; mem_ack = 0; mem_rdata = 32'h5A5A5A5A;
        se(0, 0, 1, 0, 0, 0, 0, 0);
        step();
        se(0, 0, 1, 1, 0, 17'h10200, 0, 0);
        step();
        rst = 1;
        se(1, 0, 0, 0, 0, 0, 0, 0);
        clear_model();
        step();
        rst = 0; RE = 0; mem_ack = 1;
        se(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        op(1, 0, 1, 32'h10200, 0, 1, 32'h600DF00D, 0, 1, 32'h600DF00D, 3, 0);
        op(1, 0, 1, 32'h10000, 0, 0, 32'h11112222, 0, 1, 32'h11112222, 2, 0);
        for (int i = 0; i < 600; i++) begin
            int r;
            bit [31:0] a;
            r = $urandom_range(0, 5);
            a = ($urandom & 32'hFFFE_0000) | ($urandom_range(0, 1) << 16) | ($urandom_range(0, 2) << 8)
              | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a = (a & 32'hFFFE_0003) | 32'h100;
            op(r >= 1 && r != 4, r >= 4, 3'($urandom_range(0, 7)), a, $urandom,
               int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        end
        e_chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter WIDTH, default 32, data and address width; only 32 is supported.
REQ-002 Parameter LINES, default 64, number of direct-mapped one-word lines; a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 A  input  32  byte address from the memory stage; only A[16:0] is decoded.
REQ-006 WD  input  32  store data; bytes are taken from its low-order bits.
REQ-007 modeAddr  input  3  access size: 001 word, 010 half, 011 byte, 100 unsigned half, 101 unsigned byte; other codes mean no access.
REQ-008 RE  input  1  load request.
REQ-009 WE  input  1  store request.
REQ-010 trigger  input  1  external flag, readable at address 0x100.
REQ-011 RD  output  32  load result, sign- or zero-extended.
REQ-012 stall  output  1  high while an access cannot complete; the memory stage holds A, WD, modeAddr, RE and WE stable while stall is high.
REQ-013 mem_req  output  1  backing-memory request, held high until acknowledged.
REQ-014 mem_we  output  1  1 for a write request, 0 for a read request.
REQ-015 mem_addr  output  17  word-aligned backing address (bits [1:0] are 0).
REQ-016 mem_wdata  output  32  write data, positioned in byte lanes.
REQ-017 mem_wstrb  output  4  byte-lane enables for writes.
REQ-018 mem_rdata  input  32  backing read data, valid in the cycle mem_ack is high.
REQ-019 mem_ack  input  1  one-cycle completion pulse from the backing memory.

Function
REQ-020 The cache SHALL use little-endian byte order: byte A[1:0]=0 is bits [7:0].
REQ-021 Address fields SHALL be: index = A[log2(LINES)+1:2], tag = A[16:log2(LINES)+2], with one valid bit per line.
REQ-022 Half accesses SHALL use lane A[1]; A[0] SHALL be ignored. Word accesses SHALL ignore A[1:0].
REQ-023 The FSM SHALL have three states: IDLE, FETCH and WRITE.
REQ-024 IDLE, load hit (RE=1, valid, tag match): RD is combinational in the same cycle, stall=0, no memory request.
REQ-025 IDLE, load miss: stall=1 in the same cycle, and the FSM moves to FETCH.
REQ-026 In FETCH: mem_req=1 and mem_we=0. On mem_ack, the line is written with mem_rdata, its valid bit is set and its tag is stored, and the FSM returns to IDLE.
REQ-027 The load that missed SHALL hit in the cycle after the return to IDLE, so the minimum miss penalty is 2 cycles beyond the ack latency.
REQ-028 IDLE, store (WE=1): stall=1 and the FSM moves to WRITE. The cache is write-through with no allocate on a write miss.
REQ-029 In WRITE: mem_req=1, mem_we=1, and mem_wstrb is 1111 for a word, 0011 or 1100 for a half, and a one-hot byte lane for a byte. On mem_ack, a hit line has only its strobed bytes updated, stall drops in that same cycle, and the FSM returns to IDLE.
REQ-030 RE and WE both high SHALL be treated as a store only.
REQ-031 Address 0x100 SHALL be uncached. A load there returns {31'b0, trigger} with no stall and no request. A store there is forwarded to memory like any other store but never touches the lines.
REQ-032 An invalid modeAddr code, or RE=WE=0, SHALL produce RD=0, stall=0 and no state change.
REQ-033 Sign extension SHALL use the top bit of the selected half or byte. The unsigned modes SHALL zero-fill.
REQ-034 mem_addr, mem_wdata and mem_wstrb SHALL be registered on entry to FETCH or WRITE and held stable until mem_ack.
REQ-035 A mem_ack arriving in IDLE SHALL be ignored.

Reset
REQ-036 While rst is high: all valid bits are cleared, the FSM enters IDLE, and mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
REQ-037 stall SHALL be 0 while rst is high; RD SHALL be 0 while rst is high.
REQ-038 A reset during FETCH or WRITE SHALL abandon the transaction. An outstanding mem_ack that arrives afterwards is ignored, and no line is filled.

Verification
REQ-039 Reset, then a word load at 0x10000 with backing data 0xDEADBEEF and ack after 3 cycles -> stall high for 5 cycles, then RD=0xDEADBEEF; a repeat load gives stall=0 in the same cycle.
REQ-040 After REQ-039: a signed byte load at 0x10003 -> RD=0xFFFFFFDE; an unsigned half load at 0x10002 -> RD=0x0000DEAD.
REQ-041 After REQ-039: a byte store of WD=0x55 at 0x10001 -> mem_wstrb=0010 and mem_wdata[15:8]=0x55; after the ack, a word load gives 0xDEAD55EF with no stall.
REQ-042 A load at 0x100 with trigger=1 -> RD=0x00000001, stall=0, mem_req never high.
REQ-043 A conflict miss at 0x10100 (same index, different tag) after REQ-039 -> FETCH is re-entered; a later load at 0x10000 misses again.
REQ-044 rst asserted during FETCH, with mem_ack one cycle later -> mem_req=0, and the next load to the same address misses.
